// File: rtl/setting_pkg.sv
// rtl/setting_pkg.sv - shared constants and types for the settings-screen sprite path
//
// Purpose: sprite geometry, colour key, pixel width and mode encoding used by
// setting_sprite_pipe and setting_mode_ctrl.
// Ports: none (package).
package setting_pkg;

  localparam int          SPR_W      = 132;      // 44 source pixels x 3
  localparam int          SPR_H      = 162;      // 54 source pixels x 3
  localparam int          PIX_W      = 16;
  localparam logic [15:0] KEY        = 16'h0000;
  localparam logic        MODE_PLUS  = 1'b0;
  localparam logic        MODE_MINUS = 1'b1;

  typedef enum logic {
    PLUS  = MODE_PLUS,
    MINUS = MODE_MINUS
  } mode_e;

endpackage

// File: rtl/setting_mode_ctrl.sv
// rtl/setting_mode_ctrl.sv - plus/minus sprite select FSM with frame-deferred toggling
//
// Purpose: holds the PLUS/MINUS selection and a pending-toggle flag. Presses
// accumulate (XOR) in pending and are applied only at frame_start, so a frame
// is never drawn with mixed sprites.
// Ports:
//   clk, rst     pixel clock, synchronous active-high reset
//   btn_toggle   one-cycle debounced toggle request
//   frame_start  one-cycle pulse at start of vertical blanking
//   cnt_mode     registered selection: 0 = plus, 1 = minus
module setting_mode_ctrl
  import setting_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn_toggle,
  input  logic frame_start,
  output logic cnt_mode
);

  mode_e state_q;
  logic  pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLUS;
      pending_q <= 1'b0;
    end else if (frame_start) begin
      // A press in the boundary cycle is folded in before the decision.
      if (pending_q ^ btn_toggle) begin
        state_q <= (state_q == PLUS) ? MINUS : PLUS;
      end
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_q ^ btn_toggle;
    end
  end

  assign cnt_mode = state_q;

endmodule

// File: rtl/setting_sprite_pipe.sv
// rtl/setting_sprite_pipe.sv - sprite address generation and colour-key compositing
//
// Purpose: from the scan counters and sprite origin, produce sprite-relative
// memory addresses, align window/valid/background with the memory latency and
// overlay the returned sprite pixel on the background (KEY is transparent).
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   h_cnt, v_cnt           scan position (10 bits)
//   pix_valid              scan position is in the active area
//   frame_start            start-of-vblank pulse (mode update point)
//   btn_toggle             debounced plus/minus toggle request
//   pos_x, pos_y           sprite origin
//   bg_pixel               background pixel aligned with the scan position
//   ram_data               sprite pixel returned ROM_LAT cycles after address
//   ram_addr_x, ram_addr_y registered sprite-relative address
//   cnt_mode               sprite select, 0 = plus, 1 = minus
//   pix_out, pix_out_valid composited pixel, 2 + ROM_LAT cycles after inputs
module setting_sprite_pipe
  import setting_pkg::*;
#(
  parameter int          SPR_W   = setting_pkg::SPR_W,
  parameter int          SPR_H   = setting_pkg::SPR_H,
  parameter logic [15:0] KEY     = setting_pkg::KEY,
  parameter int          ROM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  input  logic             pix_valid,
  input  logic             frame_start,
  input  logic             btn_toggle,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic [PIX_W-1:0] bg_pixel,
  input  logic [PIX_W-1:0] ram_data,
  output logic [7:0]       ram_addr_x,
  output logic [7:0]       ram_addr_y,
  output logic             cnt_mode,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_out_valid
);

  // Stages between the scan inputs and the cycle ram_data is usable.
  localparam int          DLY   = 1 + ROM_LAT;
  localparam logic [10:0] W11   = 11'(SPR_W);
  localparam logic [10:0] H11   = 11'(SPR_H);

  // Window test at 11 bits so an origin near 1023 clips rather than wraps.
  logic [10:0] x_end, y_end;
  logic        in_win, win_vld;

  assign x_end   = {1'b0, pos_x} + W11;
  assign y_end   = {1'b0, pos_y} + H11;
  assign in_win  = (h_cnt >= pos_x) && ({1'b0, h_cnt} < x_end) &&
                   (v_cnt >= pos_y) && ({1'b0, v_cnt} < y_end);
  assign win_vld = in_win && pix_valid;

  logic [7:0]       addr_x_q, addr_x_d;
  logic [7:0]       addr_y_q, addr_y_d;
  logic [DLY-1:0]   win_dly_q, vld_dly_q;
  logic [PIX_W-1:0] bg_dly_q [DLY];
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             pv_q, pv_d;

  always_comb begin
    addr_x_d = '0;
    addr_y_d = '0;
    // Offsets are < 132 and < 162, so only the low 8 bits matter.
    if (win_vld) begin
      addr_x_d = h_cnt[7:0] - pos_x[7:0];
      addr_y_d = v_cnt[7:0] - pos_y[7:0];
    end
  end

  always_comb begin
    pix_d = bg_dly_q[DLY-1];
    pv_d  = vld_dly_q[DLY-1];
    if (win_dly_q[DLY-1] && (ram_data != KEY)) begin
      pix_d = ram_data;
    end
    if (!vld_dly_q[DLY-1]) begin
      pix_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_x_q  <= '0;
      addr_y_q  <= '0;
      win_dly_q <= '0;
      vld_dly_q <= '0;
      for (int i = 0; i < DLY; i++) begin
        bg_dly_q[i] <= '0;
      end
      pix_q     <= '0;
      pv_q      <= 1'b0;
    end else begin
      addr_x_q  <= addr_x_d;
      addr_y_q  <= addr_y_d;
      win_dly_q <= {win_dly_q[DLY-2:0], win_vld};
      vld_dly_q <= {vld_dly_q[DLY-2:0], pix_valid};
      bg_dly_q[0] <= bg_pixel;
      for (int i = 1; i < DLY; i++) begin
        bg_dly_q[i] <= bg_dly_q[i-1];
      end
      pix_q     <= pix_d;
      pv_q      <= pv_d;
    end
  end

  assign ram_addr_x    = addr_x_q;
  assign ram_addr_y    = addr_y_q;
  assign pix_out       = pix_q;
  assign pix_out_valid = pv_q;

  setting_mode_ctrl u_mode_ctrl (
    .clk         (clk),
    .rst         (rst),
    .btn_toggle  (btn_toggle),
    .frame_start (frame_start),
    .cnt_mode    (cnt_mode)
  );

endmodule

// File: tb/tb_setting_sprite_pipe.sv
// tb/tb_setting_sprite_pipe.sv - directed self-checking bench for setting_sprite_pipe
module tb_setting_sprite_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt, pos_x, pos_y;
  logic        pix_valid, frame_start, btn_toggle;
  logic [15:0] bg_pixel, ram_data, pix_out;
  logic [7:0]  ram_addr_x, ram_addr_y;
  logic        cnt_mode, pix_out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  setting_sprite_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .h_cnt         (h_cnt),
    .v_cnt         (v_cnt),
    .pix_valid     (pix_valid),
    .frame_start   (frame_start),
    .btn_toggle    (btn_toggle),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .bg_pixel      (bg_pixel),
    .ram_data      (ram_data),
    .ram_addr_x    (ram_addr_x),
    .ram_addr_y    (ram_addr_y),
    .cnt_mode      (cnt_mode),
    .pix_out       (pix_out),
    .pix_out_valid (pix_out_valid)
  );

  // Sprite memory model, one cycle latency: (0,0) -> KEY, (1,0) -> 0F00,
  // everything else -> {y, x}.
  always_ff @(posedge clk) begin
    if (ram_addr_x == 8'd1 && ram_addr_y == 8'd0) ram_data <= 16'h0F00;
    else                                            ram_data <= {ram_addr_y, ram_addr_x};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scan(input logic [9:0] h, input logic [9:0] v, input logic pv, input logic [15:0] bg);
    h_cnt = h; v_cnt = v; pix_valid = pv; bg_pixel = bg;
    tick();
  endtask

  initial begin
    rst = 1'b1; h_cnt = '0; v_cnt = '0; pix_valid = 1'b0; frame_start = 1'b0;
    btn_toggle = 1'b0; pos_x = 10'd100; pos_y = 10'd50; bg_pixel = '0;
    tick(); tick();
    chk("rst_ax",   16'(ram_addr_x),    16'd0);
    chk("rst_ay",   16'(ram_addr_y),    16'd0);
    chk("rst_pix",  pix_out,            16'd0);
    chk("rst_pv",   16'(pix_out_valid), 16'd0);
    chk("rst_mode", 16'(cnt_mode),      16'd0);
    rst = 1'b0;

    // Window edges and transparency, pos = (100, 50), bg = 00F0
    scan(10'd99,  10'd50, 1'b1, 16'h00F0);
    chk("edge99_ax",  16'(ram_addr_x), 16'd0);
    scan(10'd100, 10'd50, 1'b1, 16'h00F0);
    chk("edge100_ax", 16'(ram_addr_x), 16'd0);
    chk("edge100_ay", 16'(ram_addr_y), 16'd0);
    scan(10'd231, 10'd50, 1'b1, 16'h00F0);
    chk("edge231_ax", 16'(ram_addr_x), 16'd131);
    chk("pix_h99",    pix_out, 16'h00F0);
    chk("pv_h99",     16'(pix_out_valid), 16'd1);
    scan(10'd232, 10'd50, 1'b1, 16'h00F0);
    chk("edge232_ax", 16'(ram_addr_x), 16'd0);
    chk("pix_key",    pix_out, 16'h00F0);
    scan(10'd101, 10'd50, 1'b1, 16'h00F0);
    chk("h101_ax",    16'(ram_addr_x), 16'd1);
    chk("pix_h231",   pix_out, 16'h0083);
    scan(10'd100, 10'd51, 1'b1, 16'h00F0);
    chk("v51_ay",     16'(ram_addr_y), 16'd1);
    chk("pix_h232",   pix_out, 16'h00F0);
    scan(10'd100, 10'd51, 1'b0, 16'h00F0);
    chk("novld_ay",   16'(ram_addr_y), 16'd0);
    chk("pix_sprite", pix_out, 16'h0F00);
    scan(10'd0, 10'd0, 1'b0, 16'h00F0);
    chk("pix_v51",    pix_out, 16'h0100);
    scan(10'd0, 10'd0, 1'b0, 16'h00F0);
    chk("pix_novld",  pix_out, 16'h0000);
    chk("pv_novld",   16'(pix_out_valid), 16'd0);

    // Origin clipping near 1023
    pos_x = 10'd1000;
    scan(10'd1023, 10'd50, 1'b1, 16'h1234);
    chk("clip_ax",    16'(ram_addr_x), 16'd23);
    scan(10'd5, 10'd50, 1'b1, 16'h1234);
    chk("nowrap_ax",  16'(ram_addr_x), 16'd0);
    scan(10'd0, 10'd0, 1'b0, 16'h1234);
    chk("clip_pix",   pix_out, 16'h0017);
    scan(10'd0, 10'd0, 1'b0, 16'h1234);
    chk("nowrap_pix", pix_out, 16'h1234);
    pos_x = 10'd100;

    // Mode: two presses cancel
    btn_toggle = 1'b1; tick(); tick(); btn_toggle = 1'b0; tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("two_press", 16'(cnt_mode), 16'd0);
    // Simultaneous press and frame_start
    btn_toggle = 1'b1; frame_start = 1'b1; tick();
    btn_toggle = 1'b0; frame_start = 1'b0;
    chk("simul", 16'(cnt_mode), 16'd1);
    // Mid-frame press deferred to frame_start
    btn_toggle = 1'b1; tick(); btn_toggle = 1'b0; tick(); tick();
    chk("defer_hold", 16'(cnt_mode), 16'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("defer_apply", 16'(cnt_mode), 16'd0);
    // frame_start with nothing pending
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("fs_idle", 16'(cnt_mode), 16'd0);
    btn_toggle = 1'b1; tick(); btn_toggle = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("to_minus", 16'(cnt_mode), 16'd1);

    // Reset mid-stream
    scan(10'd150, 10'd60, 1'b1, 16'h00F0);
    scan(10'd150, 10'd60, 1'b1, 16'h00F0);
    scan(10'd150, 10'd60, 1'b1, 16'h00F0);
    chk("pre_rst_pix", pix_out, 16'h0A32);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_ax",   16'(ram_addr_x),    16'd0);
    chk("mid_rst_ay",   16'(ram_addr_y),    16'd0);
    chk("mid_rst_pix",  pix_out,            16'd0);
    chk("mid_rst_pv",   16'(pix_out_valid), 16'd0);
    chk("mid_rst_mode", 16'(cnt_mode),      16'd0);
    scan(10'd150, 10'd60, 1'b1, 16'h00F0);
    chk("resume_ax",  16'(ram_addr_x),    16'd50);
    chk("resume_ay",  16'(ram_addr_y),    16'd10);
    chk("resume_pv1", 16'(pix_out_valid), 16'd0);
    scan(10'd150, 10'd60, 1'b1, 16'h00F0);
    chk("resume_pv2", 16'(pix_out_valid), 16'd0);
    scan(10'd150, 10'd60, 1'b1, 16'h00F0);
    chk("resume_pv3", 16'(pix_out_valid), 16'd1);
    chk("resume_pix", pix_out, 16'h0A32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
